// File: rtl/convolutor_job_arbiter_if.sv
// Requester/convolutor bundle for convolutor_job_arbiter.
//   slave  : the arbiter's view (requests and convolutor outputs in,
//            grants, status pulses and muxed memory traffic out)
//   master : the surrounding environment's view (directions reversed)
// Handshake: a requester holds req_i[r] until it sees gnt_o[r]. Requests
// are only sampled while the arbiter is idle. A job ends with exactly one
// one-cycle pulse on either done_o[r] or err_o[r]. state_dbg exposes the
// arbiter FSM state for observation only.
interface convolutor_job_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]              req_i;
  logic [ADDR_WIDTH-1:0]   sizeY0_i;
  logic [ADDR_WIDTH-1:0]   sizeY1_i;
  logic [DATA_WIDTH-1:0]   dataY0_i;
  logic [DATA_WIDTH-1:0]   dataY1_i;
  logic [1:0]              gnt_o;
  logic [1:0]              done_o;
  logic [1:0]              err_o;
  logic [ADDR_WIDTH-1:0]   memY_addr_o;
  logic [2*DATA_WIDTH-1:0] dataZ_o;
  logic [ADDR_WIDTH:0]     memZ_addr_o;
  logic [1:0]              writeZ_o;
  logic                    conv_start_o;
  logic [ADDR_WIDTH-1:0]   conv_sizeY_o;
  logic [DATA_WIDTH-1:0]   conv_dataY_o;
  logic [ADDR_WIDTH-1:0]   conv_memY_addr_i;
  logic [2*DATA_WIDTH-1:0] conv_dataZ_i;
  logic [ADDR_WIDTH:0]     conv_memZ_addr_i;
  logic                    conv_writeZ_i;
  logic                    conv_done_i;
  logic [2:0]              state_dbg;

  modport slave (
    input  req_i, sizeY0_i, sizeY1_i, dataY0_i, dataY1_i,
    input  conv_memY_addr_i, conv_dataZ_i, conv_memZ_addr_i,
    input  conv_writeZ_i, conv_done_i,
    output gnt_o, done_o, err_o, memY_addr_o, dataZ_o, memZ_addr_o,
    output writeZ_o, conv_start_o, conv_sizeY_o, conv_dataY_o, state_dbg
  );

  modport master (
    output req_i, sizeY0_i, sizeY1_i, dataY0_i, dataY1_i,
    output conv_memY_addr_i, conv_dataZ_i, conv_memZ_addr_i,
    output conv_writeZ_i, conv_done_i,
    input  gnt_o, done_o, err_o, memY_addr_o, dataZ_o, memZ_addr_o,
    input  writeZ_o, conv_start_o, conv_sizeY_o, conv_dataY_o, state_dbg
  );
endinterface

// File: rtl/convolutor_job_arbiter.sv
// Shares one convolutor between two requesters.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - convolutor_job_arbiter_if.slave: job requests, sizes and Y data
//           from the requesters; grant/done/err back to them; start, size
//           and muxed Y data to the convolutor; the convolutor's address,
//           Z data and Z write are broadcast, with Z writes gated per grant.
// Flow: IDLE picks a round-robin winner, START fires one start pulse, RUN
// waits for conv_done_i under a watchdog, FINISH/ABORT pulse done/err for
// one cycle and release the grant. Zero-length jobs skip straight to ABORT.
module convolutor_job_arbiter #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int WDOG_CYCLES = 1023
) (
  input logic                     clk,
  input logic                     rst_n,
  convolutor_job_arbiter_if.slave bus
);

  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_FINISH = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] size_q, size_d;
  logic                  ptr_q, ptr_d;   // index of the last requester served
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  win;
  logic [ADDR_WIDTH-1:0] win_size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      size_q  <= '0;
      ptr_q   <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      size_q  <= size_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // On a tie the requester not served last wins.
  always_comb begin
    win = 1'b0;
    if (bus.req_i == 2'b11) win = ~ptr_q;
    else                    win = bus.req_i[1];
    win_size = win ? bus.sizeY1_i : bus.sizeY0_i;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    size_d  = size_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_i) begin
          gnt_d = win ? 2'b10 : 2'b01;
          if (win_size == '0) begin
            state_d = S_ABORT;
          end else begin
            size_d  = win_size;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // Done takes priority over a simultaneous watchdog expiry.
        if (bus.conv_done_i)           state_d = S_FINISH;
        else if (wdog_q == WDOG_LAST)  state_d = S_ABORT;
      end
      S_FINISH, S_ABORT: begin
        gnt_d   = 2'b00;
        ptr_d   = gnt_q[1];
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.state_dbg    = state_q;
  assign bus.gnt_o        = gnt_q;
  assign bus.conv_start_o = (state_q == S_START);
  assign bus.conv_sizeY_o = size_q;
  assign bus.done_o       = (state_q == S_FINISH) ? gnt_q : 2'b00;
  assign bus.err_o        = (state_q == S_ABORT)  ? gnt_q : 2'b00;

  always_comb begin
    bus.conv_dataY_o = '0;
    case (gnt_q)
      2'b01:   bus.conv_dataY_o = bus.dataY0_i;
      2'b10:   bus.conv_dataY_o = bus.dataY1_i;
      default: bus.conv_dataY_o = '0;
    endcase
  end

  assign bus.writeZ_o    = {2{bus.conv_writeZ_i}} & gnt_q;
  assign bus.memY_addr_o = bus.conv_memY_addr_i;
  assign bus.memZ_addr_o = bus.conv_memZ_addr_i;
  assign bus.dataZ_o     = bus.conv_dataZ_i;

endmodule
